word_block_buffer: RTL and testbench
====================================

// Module: word_block_buffer
// PURPOSE
//   Word-to-block staging unit: a FIFO of WSIZE-bit words feeding an assembler
//   that packs WORDS_PER_BLOCK consecutive words into one wide block.
//   Sits between a word-serial producer and a block-wide consumer (cache-line fill).
//   Single clock domain; the FIFO read side is driven internally by the assembler.
// PARAMETERS
//   WSIZE            32  word width in bits
//   FIFOLEN          8   FIFO depth in words (power of two, >= 2)
//   WORDS_PER_BLOCK  4   words per block; block width = WSIZE*WORDS_PER_BLOCK
// PORTS
//   clock           in   1                  single clock, all state updates on rising edge
//   reset           in   1                  synchronous, active-high
//   write_data      in   WSIZE              word to push
//   trigger_write   in   1                  push strobe, sampled each rising edge
//   fifo_full       out  1                  FIFO holds FIFOLEN words
//   fifo_empty      out  1                  FIFO holds 0 words
//   block_out_hold  in   1                  consumer stall: 1 = keep presented block
//   block_out       out  WSIZE*WPB          assembled block
//   block_ready     out  1                  block_out valid
// BEHAVIOUR
//   - Reset (sync, high): FIFO pointers/count=0, fifo_empty=1, fifo_full=0,
//     assembler slot index=0, block_ready=0, block_out=0; partial block discarded.
//   - Push: at edge with trigger_write=1 and fifo_full=0, write_data enqueued.
//     trigger_write while fifo_full=1 -> word silently dropped, no state change.
//   - Flags derive from a registered count (0..FIFOLEN); pointers wrap modulo FIFOLEN.
//   - Pop (internal): at each edge where block_ready=0 and fifo_empty=0, the
//     head word is stored into slot[idx], idx++, count--. Head is show-ahead.
//   - A word pushed at edge N is popped no earlier than edge N+1.
//   - Simultaneous push+pop: both occur, count unchanged; push still requires
//     fifo_full=0 as sampled before the edge.
//   - Packing: first word -> block_out[WSIZE-1:0], k-th word -> bits
//     [k*WSIZE +: WSIZE] (little-endian word order).
//   - Block completion: the edge storing the last slot sets block_ready=1 and
//     resets idx to 0; block_out updated in the same edge.
//   - Handoff: at an edge with block_ready=1 and block_out_hold=0, the block is
//     consumed: block_ready->0; block_out keeps its last value. No pop happens
//     on that edge; collection resumes the next edge.
//   - While block_ready=1 and block_out_hold=1: block_out/block_ready frozen,
//     no pops; the FIFO keeps accepting pushes until full.
//   - Steady-state throughput: WORDS_PER_BLOCK words per WORDS_PER_BLOCK+1 cycles.
// CONFIGURATION
//   WBB_OVERFLOW_FLAG_EN defined: extra output fifo_overflow (1 bit), set at any
//     edge where trigger_write=1 and fifo_full=1; sticky until reset.
//   Not defined: port absent; dropped pushes leave no trace.
// TESTING
//   1 Assert reset one edge -> fifo_empty=1, fifo_full=0, block_ready=0,
//     block_out=0.
//   2 Push A0B0C0D1, B0A0D0C1, C0D0E0F1, D0C0F0E1 on consecutive edges, hold=0 ->
//     block_ready high exactly one cycle, block_out =
//     128'hD0C0F0E1_C0D0E0F1_B0A0D0C1_A0B0C0D1.
//   3 hold=1, push 0..13 on consecutive edges -> block {3,2,1,0} held, fifo_full=1
//     after word 11, words 12,13 dropped; release hold -> blocks {3..0},
//     {7..4}, {11..8} in order, then fifo_empty=1, no further block.
//   4 Push 5,6, then reset, then push 20..23 -> only block produced is
//     {23,22,21,20}; 5,6 never appear.
//   5 With WBB_OVERFLOW_FLAG_EN: fill FIFO under hold=1, push once more ->
//     fifo_overflow=1 and stays 1 until reset; without macro, same stimulus
//     gives identical block sequence.
//   6 Push continuously with hold=0 -> every 5th cycle block_ready pulses,
//     no words lost, fifo_full never asserts.

Source files
------------

// File: rtl/word_block_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : word_block_buffer
//  Purpose  : Word FIFO feeding an assembler that packs WORDS_PER_BLOCK words
//             into one wide block (little-endian word order).
//  Option   : WBB_OVERFLOW_FLAG_EN adds a sticky fifo_overflow output.
//  Revision : 1.0  initial release
// ============================================================================
module word_block_buffer #(
    parameter int WSIZE           = 32,
    parameter int FIFOLEN         = 8,
    parameter int WORDS_PER_BLOCK = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [WSIZE-1:0]                 write_data,
    input  logic                             trigger_write,
    output logic                             fifo_full,
    output logic                             fifo_empty,
    input  logic                             block_out_hold,
    output logic [WSIZE*WORDS_PER_BLOCK-1:0] block_out,
    output logic                             block_ready
`ifdef WBB_OVERFLOW_FLAG_EN
    ,
    output logic                             fifo_overflow
`endif
);

    localparam int c_PTR_W = $clog2(FIFOLEN);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_IDX_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
    localparam int c_BLK_W = WSIZE * WORDS_PER_BLOCK;
    localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(FIFOLEN);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [WSIZE-1:0]   r_mem [FIFOLEN];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [c_IDX_W-1:0] r_slot_idx;
    logic [c_BLK_W-1:0] r_stage;
    logic [c_BLK_W-1:0] r_block_out;
    state_t             r_state;
    state_t             w_state_next;

    logic               w_push;
    logic               w_pop;
    logic               w_last_slot;
    logic               w_consume;
    logic [WSIZE-1:0]   w_head;
    logic [c_BLK_W-1:0] w_stage_next;

    // ------------------------------------------------------------------
    // FIFO: flags come from the registered count, pointers wrap naturally
    // ------------------------------------------------------------------
    assign fifo_full  = (r_count == c_FULL_COUNT);
    assign fifo_empty = (r_count == '0);
    assign w_push     = trigger_write && !fifo_full;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= write_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Assembler control: collect words, then present the block until taken
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            ST_COLLECT: begin
                w_pop = !fifo_empty;
                if (w_pop && w_last_slot) begin
                    w_state_next = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // The handoff edge never pops; collection restarts next edge.
                if (!block_out_hold) begin
                    w_consume    = 1'b1;
                    w_state_next = ST_COLLECT;
                end
            end
            default: begin
                w_state_next = ST_COLLECT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Assembler datapath
    // ------------------------------------------------------------------
    assign w_last_slot = (r_slot_idx == c_LAST_IDX);

    always_comb begin
        w_stage_next = r_stage;
        w_stage_next[r_slot_idx*WSIZE +: WSIZE] = w_head;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_slot_idx  <= '0;
            r_stage     <= '0;
            r_block_out <= '0;
        end else if (w_pop) begin
            r_stage <= w_stage_next;
            if (w_last_slot) begin
                r_slot_idx  <= '0;
                r_block_out <= w_stage_next;
            end else begin
                r_slot_idx  <= r_slot_idx + 1'b1;
            end
        end
    end

    assign block_out   = r_block_out;
    assign block_ready = (r_state == ST_PRESENT);

`ifdef WBB_OVERFLOW_FLAG_EN
    logic r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (trigger_write && fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    assign fifo_overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_word_block_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_word_block_buffer
//  Purpose  : Directed self-checking bench for word_block_buffer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_word_block_buffer;

    localparam int WSIZE   = 32;
    localparam int FIFOLEN = 8;
    localparam int WPB     = 4;

    logic               clock          = 1'b0;
    logic               reset          = 1'b1;
    logic [WSIZE-1:0]   write_data     = '0;
    logic               trigger_write  = 1'b0;
    logic               block_out_hold = 1'b0;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WSIZE*WPB-1:0] block_out;
    logic               block_ready;
`ifdef WBB_OVERFLOW_FLAG_EN
    logic               fifo_overflow;
`endif

    word_block_buffer #(
        .WSIZE           (WSIZE),
        .FIFOLEN         (FIFOLEN),
        .WORDS_PER_BLOCK (WPB)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .write_data     (write_data),
        .trigger_write  (trigger_write),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .block_out_hold (block_out_hold),
        .block_out      (block_out),
        .block_ready    (block_ready)
`ifdef WBB_OVERFLOW_FLAG_EN
        ,
        .fifo_overflow  (fifo_overflow)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: consumed blocks, rising-edge cycles of block_ready.
    logic [127:0] got_q[$];
    int           rise_q[$];
    int           ready_cycles = 0;
    int           cyc          = 0;
    logic         prev_ready   = 1'b0;
    logic         full_seen    = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (block_ready === 1'b1) begin
            ready_cycles = ready_cycles + 1;
            if (!prev_ready) rise_q.push_back(cyc);
        end
        if (block_ready === 1'b1 && !block_out_hold && !reset) got_q.push_back(block_out);
        if (fifo_full === 1'b1) full_seen = 1'b1;
        prev_ready = (block_ready === 1'b1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] blk(input int w0, input int w1, input int w2, input int w3);
        return {w3[31:0], w2[31:0], w1[31:0], w0[31:0]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        trigger_write = 1'b0;
        tick();
        reset         = 1'b0;
    endtask

    task automatic clear_mon();
        got_q.delete();
        rise_q.delete();
        ready_cycles = 0;
        full_seen    = 1'b0;
    endtask

    task automatic push_burst(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            write_data    = 32'(first + i);
            trigger_write = 1'b1;
            tick();
        end
        trigger_write = 1'b0;
    endtask

    initial begin
        // 1: reset state
        tick();
        do_reset();
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_ready", block_ready, 0);
        check("rst_block", block_out, 0);

        // 2: one block with hold low
        clear_mon();
        block_out_hold = 1'b0;
        write_data = 32'hA0B0C0D1; trigger_write = 1'b1; tick();
        write_data = 32'hB0A0D0C1; tick();
        write_data = 32'hC0D0E0F1; tick();
        write_data = 32'hD0C0F0E1; tick();
        trigger_write = 1'b0;
        idle(6);
        check("t2_ready_cycles", ready_cycles, 1);
        check("t2_nblocks", got_q.size(), 1);
        check("t2_block", got_q[0], 128'hD0C0F0E1_C0D0E0F1_B0A0D0C1_A0B0C0D1);
        check("t2_block_kept", block_out, 128'hD0C0F0E1_C0D0E0F1_B0A0D0C1_A0B0C0D1);
        check("t2_ready_low", block_ready, 0);
        check("t2_empty", fifo_empty, 1);

        // 3: hold, fill, overflow drops, release
        do_reset();
        clear_mon();
        block_out_hold = 1'b1;
        for (int i = 0; i < 14; i++) begin
            write_data    = 32'(i);
            trigger_write = 1'b1;
            tick();
            if (i == 10) check("t3_not_full_w10", fifo_full, 0);
            if (i == 11) check("t3_full_w11", fifo_full, 1);
        end
        trigger_write = 1'b0;
        check("t3_held_ready", block_ready, 1);
        check("t3_held_block", block_out, blk(0, 1, 2, 3));
        check("t3_none_taken", got_q.size(), 0);
        block_out_hold = 1'b0;
        idle(30);
        check("t3_nblocks", got_q.size(), 3);
        check("t3_blk0", got_q[0], blk(0, 1, 2, 3));
        check("t3_blk1", got_q[1], blk(4, 5, 6, 7));
        check("t3_blk2", got_q[2], blk(8, 9, 10, 11));
        check("t3_empty", fifo_empty, 1);
        check("t3_ready_low", block_ready, 0);

        // 4: reset discards a partial block
        do_reset();
        clear_mon();
        push_burst(5, 2);
        do_reset();
        push_burst(20, 4);
        idle(10);
        check("t4_nblocks", got_q.size(), 1);
        check("t4_blk", got_q[0], blk(20, 21, 22, 23));

        // 5: overflow under hold
        do_reset();
        clear_mon();
        block_out_hold = 1'b1;
        for (int i = 0; i < 13; i++) begin
            write_data    = 32'(i);
            trigger_write = 1'b1;
            tick();
`ifdef WBB_OVERFLOW_FLAG_EN
            if (i == 11) check("t5_ovf_before", fifo_overflow, 0);
`endif
        end
        trigger_write = 1'b0;
        check("t5_full", fifo_full, 1);
`ifdef WBB_OVERFLOW_FLAG_EN
        check("t5_ovf_set", fifo_overflow, 1);
`endif
        block_out_hold = 1'b0;
        idle(30);
        check("t5_nblocks", got_q.size(), 3);
        check("t5_blk0", got_q[0], blk(0, 1, 2, 3));
        check("t5_blk1", got_q[1], blk(4, 5, 6, 7));
        check("t5_blk2", got_q[2], blk(8, 9, 10, 11));
`ifdef WBB_OVERFLOW_FLAG_EN
        check("t5_ovf_sticky", fifo_overflow, 1);
        do_reset();
        check("t5_ovf_cleared", fifo_overflow, 0);
`endif

        // 6: continuous stream, hold low
        do_reset();
        clear_mon();
        push_burst(100, 20);
        idle(15);
        check("t6_nblocks", got_q.size(), 5);
        for (int b = 0; b < 5; b++) begin
            check($sformatf("t6_blk%0d", b), got_q[b],
                  blk(100 + 4*b, 101 + 4*b, 102 + 4*b, 103 + 4*b));
        end
        check("t6_nrises", rise_q.size(), 5);
        for (int b = 1; b < 5; b++) begin
            check($sformatf("t6_gap%0d", b), rise_q[b] - rise_q[b-1], 5);
        end
        check("t6_ready_cycles", ready_cycles, 5);
        check("t6_never_full", full_seen, 0);
        check("t6_empty", fifo_empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
